// File: rtl/trng_pkg.sv
// Shared types, default parameters and helpers for the TRNG key pool.
package trng_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FAILED
  } trng_pool_state_e;

  localparam int unsigned DefKeyBits    = 32;
  localparam int unsigned DefFifoDepth  = 4;
  localparam int unsigned DefRepCutoff  = 32;
  localparam int unsigned DefFailThresh = 11;
  localparam int unsigned DefIntrLevel  = 1;

  // Width able to hold every level from 0 to depth inclusive.
  function automatic int unsigned level_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/trng_key_fifo.sv
// Show-ahead key FIFO with push, pop, flush and fill level.
module trng_key_fifo
  import trng_pkg::*;
#(
  parameter int unsigned DEPTH = DefFifoDepth,
  parameter int unsigned WIDTH = DefKeyBits
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  input  logic                          flush,
  output logic [WIDTH-1:0]              data,
  output logic                          empty,
  output logic                          full,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = level_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == LvlW'(DEPTH));
  assign level = count_q;
  assign data  = mem_q[rd_ptr_q];

  // A pop in the same cycle never frees room for a push while full.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + LvlW'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/trng_key_pool.sv
// TRNG back end: repetition-count health test, optional Von Neumann debiaser,
// key assembly and a buffered valid/ready key port.
module trng_key_pool
  import trng_pkg::*;
#(
  parameter int unsigned N_BITS_KEY  = DefKeyBits,
  parameter int unsigned FIFO_DEPTH  = DefFifoDepth,
  parameter int unsigned REP_CUTOFF  = DefRepCutoff,
  parameter int unsigned FAIL_THRESH = DefFailThresh,
  parameter int unsigned INTR_LEVEL  = DefIntrLevel
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable_i,
  input  logic                               clear_i,
  input  logic                               debias_en_i,
  input  logic                               raw_bit_i,
  input  logic                               raw_valid_i,
  output logic [N_BITS_KEY-1:0]              key_o,
  output logic                               key_valid_o,
  input  logic                               key_ready_i,
  output logic [level_width(FIFO_DEPTH)-1:0] fill_level_o,
  output logic                               health_err_o,
  output logic                               total_fail_o,
  output logic                               intr_o
);

  localparam int unsigned LvlW  = level_width(FIFO_DEPTH);
  localparam int unsigned RunW  = $clog2(REP_CUTOFF + 1);
  localparam int unsigned FailW = $clog2(FAIL_THRESH + 1);
  localparam int unsigned CntW  = $clog2(N_BITS_KEY);

  trng_pool_state_e state_q, state_d;
  logic [RunW-1:0]       run_cnt_q, run_cnt_d, run_next;
  logic                  last_bit_q, last_bit_d;
  logic [FailW-1:0]      fail_cnt_q, fail_cnt_d;
  logic                  phase_q, phase_d;
  logic                  b0_q, b0_d;
  logic                  debias_q, debias_d;
  logic [N_BITS_KEY-2:0] shreg_q, shreg_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                  health_err_q, health_err_d;

  logic                  cond_valid, cond_bit;
  logic [N_BITS_KEY-1:0] shifted;
  logic                  push, pop, flush;
  logic [N_BITS_KEY-1:0] fifo_data;
  logic                  fifo_empty, fifo_full;

  assign shifted = {shreg_q, cond_bit};

  always_comb begin
    state_d      = state_q;
    run_cnt_d    = run_cnt_q;
    run_next     = run_cnt_q;
    last_bit_d   = last_bit_q;
    fail_cnt_d   = fail_cnt_q;
    phase_d      = phase_q;
    b0_d         = b0_q;
    debias_d     = debias_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    health_err_d = 1'b0;
    cond_valid   = 1'b0;
    cond_bit     = 1'b0;
    push         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable_i) state_d = COLLECT;
      end
      COLLECT: begin
        if (!enable_i) begin
          state_d   = IDLE;
          shreg_d   = '0;
          bit_cnt_d = '0;
          phase_d   = 1'b0;
        end else if (raw_valid_i) begin
          if (run_cnt_q != '0 && raw_bit_i == last_bit_q) run_next = run_cnt_q + RunW'(1);
          else                                           run_next = RunW'(1);
          last_bit_d = raw_bit_i;
          if (run_next == RunW'(REP_CUTOFF)) begin
            // Zero run count so the next bit starts a fresh run regardless of value.
            health_err_d = 1'b1;
            fail_cnt_d   = fail_cnt_q + FailW'(1);
            run_cnt_d    = '0;
            shreg_d      = '0;
            bit_cnt_d    = '0;
            phase_d      = 1'b0;
          end else begin
            run_cnt_d = run_next;
            debias_d  = debias_en_i;
            if (!debias_en_i) begin
              cond_valid = 1'b1;
              cond_bit   = raw_bit_i;
              phase_d    = 1'b0;
            end else if (!phase_q || debias_en_i != debias_q) begin
              phase_d = 1'b1;
              b0_d    = raw_bit_i;
            end else begin
              phase_d    = 1'b0;
              cond_valid = (b0_q != raw_bit_i);
              cond_bit   = b0_q;
            end
          end
          // Bits arriving while the FIFO is full are dropped.
          if (cond_valid && !fifo_full) begin
            shreg_d = shifted[N_BITS_KEY-2:0];
            if (bit_cnt_q == CntW'(N_BITS_KEY - 1)) begin
              push       = 1'b1;
              bit_cnt_d  = '0;
              fail_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CntW'(1);
            end
          end
        end
      end
      FAILED: ;
      default: state_d = IDLE;
    endcase

    if (clear_i) begin
      run_cnt_d    = '0;
      fail_cnt_d   = '0;
      phase_d      = 1'b0;
      shreg_d      = '0;
      bit_cnt_d    = '0;
      health_err_d = 1'b0;
      push         = 1'b0;
    end

    if (fail_cnt_d == FailW'(FAIL_THRESH)) state_d = FAILED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      run_cnt_q    <= '0;
      last_bit_q   <= 1'b0;
      fail_cnt_q   <= '0;
      phase_q      <= 1'b0;
      b0_q         <= 1'b0;
      debias_q     <= 1'b0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      health_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      last_bit_q   <= last_bit_d;
      fail_cnt_q   <= fail_cnt_d;
      phase_q      <= phase_d;
      b0_q         <= b0_d;
      debias_q     <= debias_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      health_err_q <= health_err_d;
    end
  end

  assign flush = clear_i || (state_q == FAILED);
  assign pop   = key_valid_o && key_ready_i;

  trng_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (N_BITS_KEY)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shifted),
    .pop       (pop),
    .flush     (flush),
    .data      (fifo_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fill_level_o)
  );

  assign key_valid_o  = !fifo_empty && (state_q != FAILED);
  assign key_o        = key_valid_o ? fifo_data : '0;
  assign health_err_o = health_err_q;
  assign total_fail_o = (state_q == FAILED);
  assign intr_o       = (fill_level_o >= LvlW'(INTR_LEVEL)) || total_fail_o;

endmodule

// File: tb/tb_trng_key_pool.sv
// Directed self-checking bench for trng_key_pool with default parameters.
module tb_trng_key_pool;

  logic        clk = 1'b0;
  logic        rst, enable, clear, debias_en, raw_bit, raw_valid, key_ready;
  logic [31:0] key;
  logic        key_valid, health_err, total_fail, intr;
  logic [2:0]  fill_level;

  int n_checks = 0;
  int n_fail   = 0;
  int herr_cnt = 0;

  always #5 clk = ~clk;

  trng_key_pool dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable),
    .clear_i      (clear),
    .debias_en_i  (debias_en),
    .raw_bit_i    (raw_bit),
    .raw_valid_i  (raw_valid),
    .key_o        (key),
    .key_valid_o  (key_valid),
    .key_ready_i  (key_ready),
    .fill_level_o (fill_level),
    .health_err_o (health_err),
    .total_fail_o (total_fail),
    .intr_o       (intr)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; clear = 1'b0; debias_en = 1'b0;
    raw_bit = 1'b0; raw_valid = 1'b0; key_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    herr_cnt = 0;
  endtask

  task automatic start();
    @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      raw_valid = 1'b0;
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    raw_bit   = b;
    raw_valid = 1'b1;
    @(posedge clk);
    #1;
    if (health_err) herr_cnt++;
  endtask

  task automatic send_bits(input logic [31:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(w[i]);
  endtask

  task automatic run_ones(input int runs);
    repeat (runs * 32) send_bit(1'b1);
  endtask

  task automatic pop_one();
    @(negedge clk);
    raw_valid = 1'b0;
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({key_valid, health_err, total_fail, intr} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {key_valid, health_err, total_fail, intr});
    end
    n_checks++;
    if (key !== 32'h0 || fill_level !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_data: got key=%h level=%0d expected 0/0", key, fill_level);
    end
  endtask

  task automatic test_plain_key();
    do_reset();
    start();
    send_bits(32'hAAAA_AAAA, 31, 1);
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL plain_early_valid: got %b expected 0", key_valid);
    end
    send_bit(1'b0);
    n_checks++;
    if (key_valid !== 1'b1 || key !== 32'hAAAA_AAAA) begin
      n_fail++;
      $display("FAIL plain_key: got v=%b key=%h expected 1/aaaaaaaa", key_valid, key);
    end
    n_checks++;
    if (fill_level !== 3'd1 || intr !== 1'b1) begin
      n_fail++;
      $display("FAIL plain_level: got lvl=%0d intr=%b expected 1/1", fill_level, intr);
    end
  endtask

  task automatic test_debias();
    logic [7:0] grp;
    grp = 8'b1001_0011;
    do_reset();
    debias_en = 1'b1;
    start();
    repeat (15) send_bits({24'h0, grp}, 7, 0);
    send_bits({24'h0, grp}, 7, 5);
    n_checks++;
    if (fill_level !== 3'd0) begin
      n_fail++;
      $display("FAIL debias_early: got lvl=%0d expected 0", fill_level);
    end
    send_bit(1'b1);
    n_checks++;
    if (key_valid !== 1'b1 || key !== 32'hAAAA_AAAA) begin
      n_fail++;
      $display("FAIL debias_key: got v=%b key=%h expected 1/aaaaaaaa", key_valid, key);
    end
    send_bits({24'h0, grp}, 3, 0);
    n_checks++;
    if (fill_level !== 3'd1) begin
      n_fail++;
      $display("FAIL debias_no_emit: got lvl=%0d expected 1", fill_level);
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] words [5];
    logic [31:0] order [5];
    words = '{32'hAAAA_AAAA, 32'h1234_5678, 32'hCAFE_F00D, 32'h0F0F_0F0F, 32'hDEAD_BEEF};
    order = '{32'hAAAA_AAAA, 32'h1234_5678, 32'hCAFE_F00D, 32'h0F0F_0F0F, 32'h5A5A_5A5A};
    do_reset();
    start();
    for (int i = 0; i < 5; i++) send_bits(words[i], 31, 0);
    n_checks++;
    if (fill_level !== 3'd4 || key !== 32'hAAAA_AAAA) begin
      n_fail++;
      $display("FAIL full_level: got lvl=%0d key=%h expected 4/aaaaaaaa", fill_level, key);
    end
    pop_one();
    n_checks++;
    if (fill_level !== 3'd3) begin
      n_fail++;
      $display("FAIL full_pop: got lvl=%0d expected 3", fill_level);
    end
    send_bits(32'h5A5A_5A5A, 31, 0);
    n_checks++;
    if (fill_level !== 3'd4) begin
      n_fail++;
      $display("FAIL full_refill: got lvl=%0d expected 4", fill_level);
    end
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (key_valid !== 1'b1 || key !== order[i]) begin
        n_fail++;
        $display("FAIL full_order%0d: got v=%b key=%h expected 1/%h", i, key_valid, key, order[i]);
      end
      pop_one();
    end
    n_checks++;
    if (fill_level !== 3'd0 || key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drain: got lvl=%0d v=%b expected 0/0", fill_level, key_valid);
    end
  endtask

  task automatic test_health();
    do_reset();
    start();
    repeat (31) send_bit(1'b1);
    n_checks++;
    if (herr_cnt !== 0) begin
      n_fail++;
      $display("FAIL health_early: got %0d pulses expected 0", herr_cnt);
    end
    send_bit(1'b1);
    n_checks++;
    if (herr_cnt !== 1 || fill_level !== 3'd0) begin
      n_fail++;
      $display("FAIL health_pulse: got pulses=%0d lvl=%0d expected 1/0", herr_cnt, fill_level);
    end
    send_bits(32'hAAAA_AAAA, 31, 0);
    n_checks++;
    if (key !== 32'hAAAA_AAAA || fill_level !== 3'd1) begin
      n_fail++;
      $display("FAIL health_discard: got key=%h lvl=%0d expected aaaaaaaa/1", key, fill_level);
    end
    herr_cnt = 0;
    run_ones(10);
    n_checks++;
    if (herr_cnt !== 10 || total_fail !== 1'b0 || key_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL health_ten: got pulses=%0d tf=%b v=%b expected 10/0/1",
               herr_cnt, total_fail, key_valid);
    end
    run_ones(1);
    n_checks++;
    if (total_fail !== 1'b1 || key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL health_fail: got tf=%b v=%b expected 1/0", total_fail, key_valid);
    end
    idle(2);
    send_bits(32'hAAAA_AAAA, 31, 0);
    idle(1);
    n_checks++;
    if (fill_level !== 3'd0 || key !== 32'h0 || intr !== 1'b1 || total_fail !== 1'b1) begin
      n_fail++;
      $display("FAIL health_sticky: got lvl=%0d key=%h intr=%b tf=%b expected 0/0/1/1",
               fill_level, key, intr, total_fail);
    end
  endtask

  task automatic test_enable_drop();
    logic [31:0] exp [2];
    exp = '{32'hAAAA_AAAA, 32'h1234_5678};
    do_reset();
    start();
    send_bits(32'hAAAA_AAAA, 31, 0);
    send_bits(32'h5555_5555, 31, 16);
    @(negedge clk);
    enable = 1'b0;
    raw_valid = 1'b0;
    idle(2);
    n_checks++;
    if (fill_level !== 3'd1) begin
      n_fail++;
      $display("FAIL enable_keep: got lvl=%0d expected 1", fill_level);
    end
    start();
    send_bits(32'h1234_5678, 31, 1);
    n_checks++;
    if (fill_level !== 3'd1) begin
      n_fail++;
      $display("FAIL enable_partial: got lvl=%0d expected 1", fill_level);
    end
    send_bit(1'b0);
    n_checks++;
    if (fill_level !== 3'd2) begin
      n_fail++;
      $display("FAIL enable_full: got lvl=%0d expected 2", fill_level);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (key !== exp[i]) begin
        n_fail++;
        $display("FAIL enable_order%0d: got %h expected %h", i, key, exp[i]);
      end
      pop_one();
    end
  endtask

  task automatic test_clear_and_rst();
    do_reset();
    start();
    send_bits(32'hAAAA_AAAA, 31, 0);
    send_bits(32'h1234_5678, 31, 0);
    send_bits(32'hCAFE_F00D, 31, 0);
    @(negedge clk);
    raw_valid = 1'b0;
    clear = 1'b1;
    key_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    key_ready = 1'b0;
    n_checks++;
    if (fill_level !== 3'd0 || key !== 32'h0 || key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_pop: got lvl=%0d key=%h v=%b expected 0/0/0", fill_level, key, key_valid);
    end
    run_ones(5);
    @(negedge clk);
    raw_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    run_ones(10);
    n_checks++;
    if (total_fail !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_failcnt: got tf=%b expected 0", total_fail);
    end
    run_ones(1);
    n_checks++;
    if (total_fail !== 1'b1 || intr !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_refail: got tf=%b intr=%b expected 1/1", total_fail, intr);
    end
    do_reset();
    #1;
    n_checks++;
    if (total_fail !== 1'b0 || intr !== 1'b0 || fill_level !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_failed: got tf=%b intr=%b lvl=%0d expected 0/0/0",
               total_fail, intr, fill_level);
    end
    send_bits(32'hAAAA_AAAA, 31, 0);
    idle(1);
    n_checks++;
    if (fill_level !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_idle: got lvl=%0d expected 0", fill_level);
    end
    start();
    send_bits(32'h1234_5678, 31, 0);
    n_checks++;
    if (key_valid !== 1'b1 || key !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL rst_recover: got v=%b key=%h expected 1/12345678", key_valid, key);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clear = 1'b0; debias_en = 1'b0;
    raw_bit = 1'b0; raw_valid = 1'b0; key_ready = 1'b0;
    test_reset();
    test_plain_key();
    test_debias();
    test_fifo_full();
    test_health();
    test_enable_drop();
    test_clear_and_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
